// File: rtl/alu_muldiv_seq.sv
// Registered EX-stage ALU with a sequential multiply/divide unit, HI/LO registers,
// multiply-accumulate and a Start/Busy/Done handshake.
module alu_muldiv_seq #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int HW = (WIDTH < 16) ? WIDTH : 16;

    localparam logic [4:0] OP_MULT = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b10010;
    localparam logic [4:0] OP_DIVU = 5'b10011;
    localparam logic [4:0] OP_MADD = 5'b10100;
    localparam logic [4:0] OP_MSUB = 5'b10101;
    localparam logic [4:0] OP_MTHI = 5'b10110;
    localparam logic [4:0] OP_MTLO = 5'b10111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [SHW-1:0]     r_cnt;
    logic [4:0]         r_op;
    logic               r_neg_prod;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic [SHW-1:0]     w_sh;
    logic [SHW-1:0]     w_shl;
    logic               w_signed_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_is_multi;
    logic               w_div_zero;
    logic signed [7:0]  w_b_byte;
    logic signed [HW-1:0] w_b_half;
    logic [WIDTH-1:0]   w_sc;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [2*WIDTH-1:0] w_fix_hilo;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_sh        = A[SHW-1:0];
    assign w_shl       = SHW'(0) - w_sh;
    assign w_signed_op = (ALUControl == OP_MULT) || (ALUControl == OP_DIV) ||
                         (ALUControl == OP_MADD) || (ALUControl == OP_MSUB);
    assign w_a_neg     = w_signed_op & A[WIDTH-1];
    assign w_b_neg     = w_signed_op & B[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -A : A;
    assign w_b_mag     = w_b_neg ? -B : B;
    assign w_is_multi  = (ALUControl[4:3] == 2'b10) && (ALUControl[2:0] <= 3'd5);
    assign w_div_zero  = ((ALUControl == OP_DIV) || (ALUControl == OP_DIVU)) && (B == '0);
    assign w_b_byte    = B[7:0];
    assign w_b_half    = B[HW-1:0];

    always_comb begin
        w_sc = '0;
        case (ALUControl[3:0])
            4'h0: w_sc = A & B;
            4'h1: w_sc = A | B;
            4'h2: w_sc = A + B;
            4'h3: w_sc = A ^ B;
            4'h4: w_sc = ~(A | B);
            4'h5: w_sc = $signed(B) >>> w_sh;
            4'h6: w_sc = A - B;
            4'h7: w_sc = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'h8: w_sc = B << w_sh;
            4'h9: w_sc = B >> w_sh;
            4'hA: w_sc = {{(WIDTH-1){1'b0}}, (A < B)};
            // w_shl is -sh mod WIDTH, so a zero amount ORs B with itself
            4'hB: w_sc = (B >> w_sh) | (B << w_shl);
            4'hC: w_sc = WIDTH'(w_b_byte);
            4'hD: w_sc = WIDTH'(w_b_half);
            4'hE: w_sc = A & WIDTH'(B[HW-1:0]);
            4'hF: w_sc = B[0] ? r_lo : r_hi;
            default: w_sc = '0;
        endcase
    end

    assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvsr};
    assign w_prod_s = r_neg_prod ? -r_prod : r_prod;
    assign w_quo_s  = r_neg_prod ? -r_quo : r_quo;
    assign w_rem_s  = r_neg_rem ? -r_rem : r_rem;

    always_comb begin
        w_fix_hilo = w_prod_s;
        case (r_op)
            OP_MADD: w_fix_hilo = {r_hi, r_lo} + w_prod_s;
            OP_MSUB: w_fix_hilo = {r_hi, r_lo} - w_prod_s;
            OP_DIV, OP_DIVU: w_fix_hilo = {w_rem_s, w_quo_s};
            default: w_fix_hilo = w_prod_s;
        endcase
    end

    assign w_fix_lo = w_fix_hilo[WIDTH-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg_prod <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_mplier   <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (!ALUControl[4]) begin
                            r_result <= w_sc;
                            r_zero   <= (w_sc == '0);
                            r_done   <= 1'b1;
                            r_dbz    <= 1'b0;
                        end else if (w_div_zero) begin
                            r_hi     <= A;
                            r_lo     <= '1;
                            r_result <= '1;
                            r_zero   <= 1'b0;
                            r_done   <= 1'b1;
                            r_dbz    <= 1'b1;
                        end else if (w_is_multi) begin
                            r_state    <= S_RUN;
                            r_cnt      <= '0;
                            r_op       <= ALUControl;
                            r_neg_prod <= w_a_neg ^ w_b_neg;
                            r_neg_rem  <= w_a_neg;
                            r_mcand    <= {{WIDTH{1'b0}}, w_a_mag};
                            r_mplier   <= w_b_mag;
                            r_prod     <= '0;
                            r_rem      <= '0;
                            r_quo      <= w_a_mag;
                            r_dvsr     <= w_b_mag;
                        end else if (ALUControl == OP_MTHI) begin
                            r_hi     <= A;
                            r_result <= A;
                            r_zero   <= (A == '0);
                            r_done   <= 1'b1;
                            r_dbz    <= 1'b0;
                        end else if (ALUControl == OP_MTLO) begin
                            r_lo     <= A;
                            r_result <= A;
                            r_zero   <= (A == '0);
                            r_done   <= 1'b1;
                            r_dbz    <= 1'b0;
                        end else begin
                            r_result <= '0;
                            r_zero   <= 1'b1;
                            r_done   <= 1'b1;
                            r_dbz    <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Both units step every cycle; FIX picks the one the opcode needs
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi     <= w_fix_hilo[2*WIDTH-1:WIDTH];
                    r_lo     <= w_fix_lo;
                    r_result <= w_fix_lo;
                    r_zero   <= (w_fix_lo == '0);
                    r_done   <= 1'b1;
                    r_dbz    <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign Hi        = r_hi;
    assign Lo        = r_lo;
    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;
    assign DivByZero = r_dbz;

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Parametrised, registered successor to the datapath ALU. It adds a multi-cycle multiply/divide unit with architectural HI/LO registers, multiply-accumulate, and a Start/Busy/Done handshake. Every result is registered, and Zero is computed from the same result it flags. It sits in the EX stage, and the hazard unit stalls the pipeline while Busy is high.

## Interface
- WIDTH, 32, datapath width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  accept the operation on ALUControl/A/B this cycle; ignored while Busy=1.
- ALUControl  input  5  operation select.
- A  input  WIDTH  operand A; also the shift amount, taken from A[SHW-1:0].
- B  input  WIDTH  operand B.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered; equals (ALUResult == 0) in the same cycle.
- Hi, Lo  output  WIDTH  architectural HI/LO registers.
- Busy  output  1  multi-cycle operation in progress.
- Done  output  1  one-cycle pulse: the accepted operation has completed.
- DivByZero  output  1  registered; set with Done of a DIV/DIVU whose B=0, otherwise 0 on each Done.

## Operation
- Single-cycle ops, 0xxxx:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 00100 NOR.
  - 00101 SRA (arithmetic), 00110 SUB, 00111 SLT (signed).
  - 01000 SLL, 01001 SRL, 01010 SLTU, 01011 ROTR.
  - 01100 SEB, 01101 SEH, 01110 ANDI (A & zero-extended B[15:0]), 01111 MFHI/MFLO select (B[0]=0 gives Hi, B[0]=1 gives Lo).
- Arithmetic wraps modulo 2^WIDTH; no overflow flag. Shifts and ROTR use A[SHW-1:0]; ROTR by 0 returns B unchanged.
- Multi-cycle ops (Busy asserted):
  - 10000 MULT, 10001 MULTU: {Hi,Lo} = A*B, full 2*WIDTH-bit product, signed or unsigned respectively.
  - 10010 DIV, 10011 DIVU: Lo = quotient, Hi = remainder. Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - 10100 MADD, 10101 MSUB: {Hi,Lo} = {Hi,Lo} +/- signed A*B, wrapping at 2*WIDTH bits.
- Register-write ops, single cycle: 10110 MTHI (Hi=A), 10111 MTLO (Lo=A).
- Codes 11000–11111: no-op. Done still pulses, ALUResult=0, Zero=1.
- Multiplier: radix-2 shift-add on operand magnitudes, sign fixed at completion.
- Divider: restoring division on magnitudes, one quotient bit per cycle, sign fixed at completion.
- Multi-cycle completion: ALUResult=new Lo, Zero=(new Lo==0).
- Single-cycle and MTHI/MTLO ops leave Hi/Lo unchanged except for the written register.
- DIV/DIVU with B=0: no iteration. Hi=A, Lo=all ones, DivByZero=1, completes on the next cycle like a single-cycle op.
- Signed overflow, DIV with A=MIN and B=-1: Lo=MIN, Hi=0, normal latency.
- State machine: IDLE -> (Start & multi-cycle op) -> RUN -> (iteration counter == WIDTH-1) -> FIX -> IDLE.
  - Operands and the opcode are latched on acceptance.
  - FIX applies sign correction and the accumulate step, writes Hi/Lo/ALUResult, and pulses Done.

## Timing
- Reset (synchronous) sets:
  - State=IDLE, counter=0.
  - ALUResult=0, Zero=1, Hi=0, Lo=0.
  - Busy=0, Done=0, DivByZero=0.
- Reset during RUN or FIX aborts the operation; Hi/Lo are cleared and no Done is issued.
- Single-cycle op accepted at edge N: ALUResult/Zero/Done valid after edge N+1; Done is high for exactly one cycle.
- Multi-cycle op accepted at edge N:
  - Busy=1 from after edge N+1 through edge N+WIDTH+1.
  - Done=1 and Hi/Lo/ALUResult valid after edge N+WIDTH+2; Busy drops in that same cycle.
  - Total latency WIDTH+2.
- Start with Busy=1 is ignored entirely: no state change, no Done.
- Start in the cycle Done pulses (Busy=0) is accepted: back-to-back issue, no gap.
- With Start=0, outputs hold their values; only Done returns to 0.
- Zero never lags ALUResult. Both are written on the same edge.

## Test plan
- Reset, then ADD A=0xFFFFFFFF B=1 -> after one cycle ALUResult=0, Zero=1, Done pulse; next op SUB 5-3 -> ALUResult=2, Zero=0 on the same edge.
- SRA A=4 B=0x80000000 -> 0xF8000000; ROTR A=0 B=0x12345678 -> 0x12345678; SLTU A=1 B=0xFFFFFFFF -> 1; SLT with the same operands -> 0.
- MULT A=-3 B=7 -> Done exactly 34 cycles after Start, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; MULTU 0xFFFFFFFF x 2 -> Hi=1, Lo=0xFFFFFFFE; Start pulsed mid-operation has no effect.
- DIV A=-7 B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV A=9 B=0 -> Hi=9, Lo=0xFFFFFFFF, DivByZero=1, Done after 1 cycle; DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
- MTLO 0xFFFFFFFF, MTHI 0, then MADD A=1 B=1 -> Hi=1, Lo=0, ALUResult=0, Zero=1; MSUB A=1 B=1 -> Hi=0, Lo=0xFFFFFFFF.
- Reset asserted 10 cycles into DIVU -> no Done, Hi=Lo=0, Busy=0 next cycle; rerun with WIDTH=16 MULTU 0xFFFF x 0xFFFF -> Hi=0xFFFE, Lo=0x0001, latency 18.
